minimig_host_bus_master: RTL and testbench

- Upstream master for the host (UserIO) port of the 68000 bus bridge.
- Takes a byte-wide command stream from the UserIO/SPI layer and halts the CPU. It then runs auto-incrementing 16-bit word reads and writes through host_cs/host_we/host_bs/host_adr/host_wdat, completing each on host_ack.
- Releases the CPU when the transfer is finished, times out, or is aborted.

---
 rtl/minimig_host_bus_master.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_minimig_host_bus_master.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minimig_host_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : minimig_host_bus_master                                      |
// | Description : Upstream master for the host (UserIO) port of the 68000 bus  |
// |               bridge. Parses a byte-wide command stream, halts the CPU,    |
// |               runs auto-incrementing 16-bit word reads/writes on the host  |
// |               bus and streams read data back out byte by byte.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module minimig_host_bus_master #(
  parameter int ACK_TIMEOUT = 1023,  // clk cycles from host_cs to host_ack before giving up
  parameter int HALT_SETTLE = 2      // consecutive clk7_en samples with as_n=1 to own the bus
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk7_en,
  input  logic        as_n,
  input  logic        cmd_valid,
  input  logic [7:0]  cmd_data,
  output logic        cmd_ready,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  input  logic        abort,
  output logic        cpu_halt,
  output logic        host_cs,
  output logic        host_we,
  output logic [1:0]  host_bs,
  output logic [23:1] host_adr,
  output logic [15:0] host_wdat,
  input  logic [15:0] host_rdat,
  input  logic        host_ack,
  output logic        busy,
  output logic        error
);

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;
  localparam logic [9:0] TMO_LAST    = 10'(ACK_TIMEOUT - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(HALT_SETTLE - 1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_HDR       = 4'd1,
    ST_HALT_REQ  = 4'd2,
    ST_WAIT_HALT = 4'd3,
    ST_WFETCH    = 4'd4,
    ST_BUS       = 4'd5,
    ST_RELEASE   = 4'd6,
    ST_RDOUT     = 4'd7,
    ST_DONE      = 4'd8
  } state_t;

  // Control state
  state_t      state_q,   state_d;
  logic        op_wr_q,   op_wr_d;     // 1 = current command is a write
  logic [2:0]  hdr_cnt_q, hdr_cnt_d;   // header byte index 0..4
  logic [15:0] n_q,       n_d;         // words still to transfer
  logic        wbyte_q,   wbyte_d;     // 0 = next write byte is the high byte
  logic        rbyte_q,   rbyte_d;     // 0 = high read byte currently presented
  logic [15:0] hold_q,    hold_d;      // read data captured on host_ack
  logic [7:0]  settle_q,  settle_d;    // consecutive idle-bus clk7 samples
  logic [9:0]  tmo_q,     tmo_d;       // cycles spent in BUS waiting for ack
  logic        rel7_q,    rel7_d;      // a clk7_en has been seen in RELEASE

  // Registered outputs
  logic        cmd_ready_q, cmd_ready_d;
  logic        rd_valid_q,  rd_valid_d;
  logic [7:0]  rd_data_q,   rd_data_d;
  logic        halt_q,      halt_d;
  logic        cs_q,        cs_d;
  logic        we_q,        we_d;
  logic [22:0] adr_q,       adr_d;
  logic [15:0] wdat_q,      wdat_d;
  logic        busy_q,      busy_d;
  logic        error_q,     error_d;

  logic        cmd_take;
  logic        rd_take;

  assign cmd_take = cmd_valid & cmd_ready_q;
  assign rd_take  = rd_valid_q & rd_ready;

  // Next-state and next-output computation for the transfer sequencer
  always_comb begin
    state_d    = state_q;
    op_wr_d    = op_wr_q;
    hdr_cnt_d  = hdr_cnt_q;
    n_d        = n_q;
    wbyte_d    = wbyte_q;
    rbyte_d    = rbyte_q;
    hold_d     = hold_q;
    settle_d   = settle_q;
    tmo_d      = (state_q == ST_BUS) ? tmo_q : 10'd0;
    rel7_d     = rel7_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    error_d    = error_q;

    case (state_q)
      ST_IDLE: begin
        // Unknown opcodes are swallowed without leaving IDLE
        if (cmd_take && (cmd_data == OP_WRITE || cmd_data == OP_READ)) begin
          op_wr_d   = (cmd_data == OP_WRITE);
          error_d   = 1'b0;
          hdr_cnt_d = 3'd0;
          state_d   = ST_HDR;
        end
      end

      ST_HDR: begin
        if (cmd_take) begin
          case (hdr_cnt_q)
            3'd0:    adr_d[22:15] = cmd_data;
            3'd1:    adr_d[14:7]  = cmd_data;
            3'd2:    adr_d[6:0]   = cmd_data[7:1];  // byte address bit 0 dropped
            3'd3:    n_d[15:8]    = cmd_data;
            default: n_d[7:0]     = cmd_data;
          endcase
          hdr_cnt_d = hdr_cnt_q + 3'd1;
          if (hdr_cnt_q == 3'd4) begin
            // A zero word count finishes here: no halt, no bus cycle
            state_d = ({n_q[15:8], cmd_data} == 16'd0) ? ST_IDLE : ST_HALT_REQ;
          end
        end
      end

      ST_HALT_REQ: begin
        settle_d = 8'd0;
        state_d  = ST_WAIT_HALT;
      end

      ST_WAIT_HALT: begin
        if (clk7_en) begin
          if (!as_n) begin
            settle_d = 8'd0;
          end else if (settle_q == SETTLE_LAST) begin
            settle_d = 8'd0;
            wbyte_d  = 1'b0;
            state_d  = op_wr_q ? ST_WFETCH : ST_BUS;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
      end

      ST_WFETCH: begin
        if (cmd_take) begin
          if (!wbyte_q) begin
            wdat_d[15:8] = cmd_data;
            wbyte_d      = 1'b1;
          end else begin
            wdat_d[7:0]  = cmd_data;
            wbyte_d      = 1'b0;
            state_d      = ST_BUS;
          end
        end
      end

      ST_BUS: begin
        // An ack arriving on the final timeout cycle still completes the access
        if (host_ack) begin
          if (!op_wr_q) begin
            hold_d = host_rdat;
          end
          rel7_d  = 1'b0;
          state_d = ST_RELEASE;
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end

      ST_RELEASE: begin
        if (clk7_en) begin
          rel7_d = 1'b1;
        end
        if (!host_ack && (rel7_q || clk7_en)) begin
          adr_d = adr_q + 23'd1;  // natural 23-bit wrap 0x7FFFFF -> 0
          n_d   = n_q - 16'd1;
          if (!op_wr_q) begin
            rd_data_d  = hold_q[15:8];
            rd_valid_d = 1'b1;
            rbyte_d    = 1'b0;
            state_d    = ST_RDOUT;
          end else if (n_q == 16'd1) begin
            state_d = ST_DONE;
          end else begin
            wbyte_d = 1'b0;
            state_d = ST_WFETCH;
          end
        end
      end

      ST_RDOUT: begin
        if (rd_take) begin
          if (!rbyte_q) begin
            rd_data_d = hold_q[7:0];
            rbyte_d   = 1'b1;
          end else begin
            rd_valid_d = 1'b0;
            rbyte_d    = 1'b0;
            state_d    = (n_q == 16'd0) ? ST_DONE : ST_BUS;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides any completion or timeout in the same cycle
    if (abort && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d    = ST_DONE;
      rd_valid_d = 1'b0;
      hold_d     = hold_q;
      error_d    = error_q;
    end

    // Outputs are decoded from the next state so they appear with it
    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_HDR) || (state_d == ST_WFETCH);
    cs_d        = (state_d == ST_BUS);
    we_d        = (state_d == ST_BUS) && op_wr_d;
    busy_d      = (state_d != ST_IDLE);
    // Halt is held through DONE only if it was already up (aborted headers never halt)
    halt_d      = (state_d inside {ST_HALT_REQ, ST_WAIT_HALT, ST_WFETCH, ST_BUS,
                                   ST_RELEASE, ST_RDOUT})
                  || ((state_d == ST_DONE) && halt_q);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_wr_q     <= 1'b0;
      hdr_cnt_q   <= 3'd0;
      n_q         <= 16'd0;
      wbyte_q     <= 1'b0;
      rbyte_q     <= 1'b0;
      hold_q      <= 16'd0;
      settle_q    <= 8'd0;
      tmo_q       <= 10'd0;
      rel7_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'd0;
      halt_q      <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 23'd0;
      wdat_q      <= 16'd0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_wr_q     <= op_wr_d;
      hdr_cnt_q   <= hdr_cnt_d;
      n_q         <= n_d;
      wbyte_q     <= wbyte_d;
      rbyte_q     <= rbyte_d;
      hold_q      <= hold_d;
      settle_q    <= settle_d;
      tmo_q       <= tmo_d;
      rel7_q      <= rel7_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      halt_q      <= halt_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      wdat_q      <= wdat_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign cpu_halt  = halt_q;
  assign host_cs   = cs_q;
  assign host_we   = we_q;
  assign host_bs   = 2'b11;
  assign host_adr  = adr_q;
  assign host_wdat = wdat_q;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_minimig_host_bus_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_minimig_host_bus_master                                   |
// | Description : Randomized self-checking bench for the host bus master.      |
// |               A bus responder, a read consumer and a monitor run in the    |
// |               background; expectations come from per-transfer word lists.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_minimig_host_bus_master;

  localparam int ACK_TIMEOUT = 1023;
  localparam int HALT_SETTLE = 2;

  logic        clk;
  logic        rst;
  logic        clk7_en;
  logic        as_n;
  logic        cmd_valid;
  logic [7:0]  cmd_data;
  logic        cmd_ready;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic        abort;
  logic        cpu_halt;
  logic        host_cs;
  logic        host_we;
  logic [1:0]  host_bs;
  logic [23:1] host_adr;
  logic [15:0] host_wdat;
  logic [15:0] host_rdat;
  logic        host_ack;
  logic        busy;
  logic        error;

  minimig_host_bus_master #(
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .HALT_SETTLE (HALT_SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk7_en   (clk7_en),
    .as_n      (as_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .abort     (abort),
    .cpu_halt  (cpu_halt),
    .host_cs   (host_cs),
    .host_we   (host_we),
    .host_bs   (host_bs),
    .host_adr  (host_adr),
    .host_wdat (host_wdat),
    .host_rdat (host_rdat),
    .host_ack  (host_ack),
    .busy      (busy),
    .error     (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Background environment controls
  bit          as_force_low  = 1'b0;
  bit          ack_hold      = 1'b0;
  int          ack_delay_fix = 0;
  bit          rd_hold       = 1'b0;
  logic [15:0] mem [int];

  // Current transfer description
  bit          xwr;
  logic [22:0] xbase;
  int          xn;
  logic [15:0] xd[$];

  // Monitor logs
  logic [22:0] log_adr[$];
  logic        log_we[$];
  logic [1:0]  log_bs[$];
  logic [15:0] log_wdat[$];
  int          log_rdn[$];
  logic [7:0]  rd_log[$];
  int          cs_count    = 0;
  int          halt_rise   = 0;
  int          settle_seen = 0;

  // clk7_en every 4th clk and a CPU address strobe that is busy at random
  initial begin
    int cyc;
    cyc = 0;
    clk7_en = 1'b0;
    as_n    = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      clk7_en = (cyc % 4 == 0);
      as_n    = as_force_low ? 1'b0 : ($urandom_range(0, 4) != 0);
    end
  end

  // Host bus responder: ack after a delay, return read data from mem
  initial begin
    int cnt;
    int dly;
    cnt = 0;
    dly = 1;
    host_ack  = 1'b0;
    host_rdat = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (host_ack) begin
        if (!host_cs) host_ack = 1'b0;
      end else if (host_cs && !ack_hold) begin
        if (cnt == 0) dly = (ack_delay_fix != 0) ? ack_delay_fix : $urandom_range(1, 10);
        cnt++;
        if (cnt >= dly) begin
          host_ack  = 1'b1;
          host_rdat = mem.exists(int'(host_adr)) ? mem[int'(host_adr)] : 16'hDEAD;
          cnt       = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Read-data consumer with random back-pressure
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      rd_ready = !rd_hold && ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: log bus accesses and consumed read bytes, police halt ownership
  initial begin
    bit prev_cs;
    bit prev_halt;
    bit first_in_halt;
    prev_cs = 1'b0;
    prev_halt = 1'b0;
    first_in_halt = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_valid && rd_ready) rd_log.push_back(rd_data);
      if (cpu_halt && !prev_halt) begin
        halt_rise++;
        settle_seen   = 0;
        first_in_halt = 1'b1;
      end
      if (cpu_halt && clk7_en) settle_seen = as_n ? settle_seen + 1 : 0;
      if (host_cs && !prev_cs) begin
        cs_count++;
        log_adr.push_back(host_adr);
        log_we.push_back(host_we);
        log_bs.push_back(host_bs);
        log_wdat.push_back(host_wdat);
        log_rdn.push_back(rd_log.size());
        check_eq("halt_during_cs", cpu_halt, 1);
        if (first_in_halt) begin
          check_eq("halt_settle", settle_seen >= HALT_SETTLE, 1);
          first_in_halt = 1'b0;
        end
      end
      prev_cs   = host_cs;
      prev_halt = cpu_halt;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (1) begin
      @(negedge clk);
      if (cmd_ready) break;
      t++;
      if (t > 3000) begin
        check_eq("cmd_ready_wait", cmd_ready, 1);
        break;
      end
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (!busy) break;
      t++;
      if (t > budget) begin
        check_eq("idle_wait", busy, 0);
        break;
      end
    end
    tick();
  endtask

  task automatic wait_cs(input int budget);
    int t;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (host_cs) break;
      t++;
      if (t > budget) begin
        check_eq("cs_wait", host_cs, 1);
        break;
      end
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_host_cs",   host_cs,  0);
    check_eq("rst_rd_valid",  rd_valid, 0);
    check_eq("rst_cpu_halt",  cpu_halt, 0);
    check_eq("rst_busy",      busy,     0);
    check_eq("rst_host_adr",  host_adr, 0);
    check_eq("rst_wdat_rdat", {host_wdat, rd_data}, 0);
    check_eq("rst_misc",      {cmd_ready, host_we, host_bs, error}, 5'b00110);
  endtask

  task automatic start_xfer(input bit wr, input logic [23:0] a, input int n);
    logic [22:0] adr;
    logic [15:0] w;
    xwr   = wr;
    xbase = a[23:1];
    xn    = n;
    log_adr.delete(); log_we.delete(); log_bs.delete();
    log_wdat.delete(); log_rdn.delete(); rd_log.delete();
    if (!wr) begin
      for (int i = 0; i < n; i++) begin
        adr = xbase + 23'(i);
        mem[int'(adr)] = xd[i];
      end
    end
    send_byte(wr ? 8'h01 : 8'h02);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
    send_byte(8'(n >> 8));
    send_byte(8'(n));
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        w = xd[i];
        send_byte(w[15:8]);
        send_byte(w[7:0]);
      end
    end
  endtask

  task automatic finish_xfer();
    logic [22:0] ea;
    logic [15:0] w;
    logic [7:0]  eb;
    int m;
    wait_idle(6000);
    check_eq("access_count", log_adr.size(), xn);
    m = (log_adr.size() < xn) ? log_adr.size() : xn;
    for (int i = 0; i < m; i++) begin
      ea = xbase + 23'(i);
      w  = xd[i];
      check_eq("host_adr", log_adr[i], ea);
      check_eq("host_we",  log_we[i],  xwr);
      check_eq("host_bs",  log_bs[i],  2'b11);
      if (xwr) check_eq("host_wdat", log_wdat[i], w);
      else     check_eq("rd_drained_before_cs", log_rdn[i], 2 * i);
    end
    if (!xwr) begin
      check_eq("rd_byte_count", rd_log.size(), 2 * xn);
      m = (rd_log.size() < 2 * xn) ? rd_log.size() : 2 * xn;
      for (int i = 0; i < m; i++) begin
        w  = xd[i / 2];
        eb = (i % 2 == 0) ? w[15:8] : w[7:0];
        check_eq("rd_data", rd_log[i], eb);
      end
    end
    check_eq("halt_released", cpu_halt, 0);
    check_eq("error_idle", error, 0);
  endtask

  initial begin
    int c0;
    int h0;
    int t;
    logic [23:0] a;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    abort     = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs();
    tick();
    rst = 1'b0;
    tick();
    check_eq("idle_cmd_ready", cmd_ready, 1);

    // Directed write: two words, ack 8 cycles after cs
    ack_delay_fix = 8;
    xd = '{16'hABCD, 16'h1234};
    start_xfer(1'b1, 24'h001000, 2);
    finish_xfer();
    ack_delay_fix = 0;

    // Directed read across the address wrap, with consumer stalled
    rd_hold = 1'b1;
    xd = '{16'h5AA5, 16'hC33C};
    c0 = cs_count;
    start_xfer(1'b0, 24'hFFFFFE, 2);
    t = 0;
    while (!rd_valid && t < 2000) begin tick(); t++; end
    repeat (20) tick();
    check_eq("no_cs_while_rd_pending", cs_count - c0, 1);
    rd_hold = 1'b0;
    finish_xfer();

    // Halt settle: bus stays busy for 30 cycles after halt
    as_force_low = 1'b1;
    xd = '{16'h0F1E};
    c0 = cs_count;
    start_xfer(1'b0, 24'h020304, 1);
    t = 0;
    while (!cpu_halt && t < 100) begin tick(); t++; end
    repeat (30) tick();
    check_eq("no_cs_while_as_low", cs_count - c0, 0);
    as_force_low = 1'b0;
    finish_xfer();

    // Timeout: ack never comes
    ack_hold = 1'b1;
    xd = '{16'h7777};
    start_xfer(1'b0, 24'h400000, 1);
    wait_cs(200);
    t = 0;
    while (1) begin
      @(negedge clk);
      t++;
      if (error || t > 1200) break;
    end
    check_eq("timeout_cycle", t, ACK_TIMEOUT);
    check_eq("timeout_cs_low", host_cs, 0);
    wait_idle(20);
    check_eq("timeout_halt", cpu_halt, 0);
    check_eq("timeout_busy", busy, 0);
    check_eq("timeout_error", error, 1);
    ack_hold = 1'b0;

    // Invalid opcode, then a zero-length command (also clears error)
    c0 = cs_count;
    h0 = halt_rise;
    send_byte(8'h07);
    check_eq("bad_op_busy", busy, 0);
    check_eq("bad_op_error_kept", error, 1);
    check_eq("bad_op_ready", cmd_ready, 1);
    send_byte(8'h01);
    check_eq("opcode_clears_error", error, 0);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    send_byte(8'h00); send_byte(8'h00);
    repeat (4) tick();
    check_eq("n0_busy", busy, 0);
    check_eq("n0_ready", cmd_ready, 1);
    check_eq("n0_no_halt", halt_rise - h0, 0);
    check_eq("n0_no_cs", cs_count - c0, 0);

    // Randomized transfers
    for (int k = 0; k < 10; k++) begin
      int n;
      bit wr;
      wr = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 4);
      a  = 24'($urandom);
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFF8 | 24'($urandom_range(0, 7));
      xd.delete();
      for (int i = 0; i < n; i++) xd.push_back(16'($urandom));
      start_xfer(wr, a, n);
      finish_xfer();
    end

    // Abort during BUS of a 4-word read
    ack_hold = 1'b1;
    xd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    start_xfer(1'b0, 24'h00ABC0, 4);
    wait_cs(200);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_cs", host_cs, 0);
    check_eq("abort_rd_valid", rd_valid, 0);
    @(negedge clk);
    check_eq("abort_halt", cpu_halt, 0);
    check_eq("abort_error", error, 0);
    ack_hold = 1'b0;
    wait_idle(20);

    // Reset during BUS
    ack_hold = 1'b1;
    xd = '{16'h9999, 16'h8888};
    start_xfer(1'b0, 24'h123456, 2);
    wait_cs(200);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    ack_hold = 1'b0;
    repeat (3) tick();
    check_eq("post_rst_ready", cmd_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
